// File: rtl/spi_pkg.sv
// Shared types for the SPI arbiter: sequencer state encoding and counter sizing.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_WAIT_LO,
      ST_WAIT_HI,
      ST_DONE
   } state_e;

   // Width of a counter that must be able to hold the value TIMEOUT itself.
   function automatic int cnt_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping to 0.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] win_o,
   output logic [PW-1:0]   idx_o
);

   always_comb begin
      int          j;
      logic        found;
      logic [PW-1:0] jj;
      win_o = '0;
      idx_o = '0;
      found = 1'b0;
      j     = 0;
      jj    = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NREQ) j = j - NREQ;
         jj = PW'(j);
         if (!found && req_i[jj]) begin
            found     = 1'b1;
            win_o[jj] = 1'b1;
            idx_o     = jj;
         end
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Round-robin arbiter and transaction sequencer sharing one spi_master among NREQ requesters.
module spi_arbiter
   import spi_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 13,
   parameter int TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] tx_dat,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      rx_dat,
   output logic                  err,
   output logic                  busy,
   output logic                  m_st,
   output logic [WIDTH-1:0]      m_din,
   input  logic                  m_load,
   input  logic [WIDTH-1:0]      m_dout,
   output state_e                dbg_state_o
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = cnt_width(TIMEOUT);

   // Handshake: a requester raises req and holds it; gnt marks the requester being served from
   // selection onward; a single-cycle ack (with rx_dat, and err on timeout) ends the transaction,
   // after which the requester may drop req or keep it high to queue another transfer.

   state_e            state_q;
   logic [PW-1:0]     ptr_q, g_q, ptr_d, win_idx;
   logic [NREQ-1:0]   gnt_q, ack_q, win, req_eff;
   logic [WIDTH-1:0]  rx_q, m_din_q, tx_sel;
   logic              err_q, busy_q, m_st_q, err_flag_q;
   logic [CW-1:0]     cnt_q, cnt_d;

   // The requester being acked this cycle may not yet have dropped its level request.
   assign req_eff = req & ~ack_q;

   rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
      .req_i (req_eff),
      .ptr_i (ptr_q),
      .win_o (win),
      .idx_o (win_idx)
   );

   always_comb begin
      tx_sel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (g_q == PW'(i)) tx_sel = tx_dat[i*WIDTH +: WIDTH];
      end
   end

   assign ptr_d = (g_q == PW'(NREQ - 1)) ? '0 : g_q + PW'(1);
   assign cnt_d = cnt_q + CW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         g_q        <= '0;
         gnt_q      <= '0;
         ack_q      <= '0;
         rx_q       <= '0;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
         m_st_q     <= 1'b0;
         m_din_q    <= '0;
         cnt_q      <= '0;
         err_flag_q <= 1'b0;
      end else begin
         ack_q  <= '0;
         err_q  <= 1'b0;
         m_st_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (|req_eff) begin
                  gnt_q      <= win;
                  g_q        <= win_idx;
                  busy_q     <= 1'b1;
                  err_flag_q <= 1'b0;
                  state_q    <= ST_START;
               end
            end
            ST_START: begin
               m_din_q <= tx_sel;
               m_st_q  <= 1'b1;
               cnt_q   <= '0;
               state_q <= ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
               cnt_q <= cnt_d;
               if (!m_load) begin
                  state_q <= ST_WAIT_HI;
               end else if (cnt_d == CW'(TIMEOUT)) begin
                  err_flag_q <= 1'b1;
                  state_q    <= ST_DONE;
               end
            end
            ST_WAIT_HI: begin
               if (m_load) state_q <= ST_DONE;
            end
            ST_DONE: begin
               if (!err_flag_q) rx_q <= m_dout;
               ack_q   <= gnt_q;
               err_q   <= err_flag_q;
               gnt_q   <= '0;
               ptr_q   <= ptr_d;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt         = gnt_q;
   assign ack         = ack_q;
   assign rx_dat      = rx_q;
   assign err         = err_q;
   assign busy        = busy_q;
   assign m_st        = m_st_q;
   assign m_din       = m_din_q;
   assign dbg_state_o = state_q;

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and transaction sequencer that lets up to NREQ independent requesters share one `spi_master` instance. It picks one pending requester, loads its word into the master, pulses start, and tracks the master's `load` handshake through the frame. It then returns the received word to that requester with a one-cycle acknowledge. It sits between the board-level clients (register blocks, test pattern generators) and the `spi_master`/`spi_slave` pair.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `WIDTH`, 13: SPI frame width; must match the attached `spi_master`.
- `TIMEOUT`, 16: maximum cycles allowed between `m_st` and `m_load` falling.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester transfer request; level, held until `ack`.
- `tx_dat`  in  NREQ*WIDTH  per-requester transmit word; requester i occupies bits [i*WIDTH +: WIDTH].
- `gnt`  out  NREQ  one-hot grant; held from selection until `ack`.
- `ack`  out  NREQ  one-cycle completion pulse to the granted requester.
- `rx_dat`  out  WIDTH  received word; valid in the `ack` cycle and held until the next `ack`.
- `err`  out  1  one-cycle pulse with `ack` when the master did not start within TIMEOUT.
- `busy`  out  1  high in every state except IDLE.
- `m_st`  out  1  start pulse to `spi_master`.
- `m_din`  out  WIDTH  transmit word to `spi_master`.
- `m_load`  in  1  master `load`; high when idle, low during a frame.
- `m_dout`  in  WIDTH  master receive word.

## Operation
- FSM states and transitions:
  - IDLE: when any `req` is set, latch the winner, assert `gnt`, go to START.
  - START: register `m_din` = winner's `tx_dat`, pulse `m_st` for exactly 1 cycle, go to WAIT_LO.
  - WAIT_LO: wait for `m_load`=0, then go to WAIT_HI. If the timeout counter reaches TIMEOUT first, set an internal error flag and go to DONE.
  - WAIT_HI: wait for `m_load`=1, then go to DONE. This state has no timeout; frame length is bounded by the master.
  - DONE: latch `m_dout` into `rx_dat` (unless the error flag is set, in which case `rx_dat` is kept), pulse `ack[g]` and `err` if flagged, clear `gnt`, advance the pointer, go to IDLE.
- Winner selection is round-robin: the first set `req` bit searching upward from `ptr`, wrapping at NREQ-1 to 0.
- `ptr` update: after DONE, `ptr` = g+1, wrapping to 0 when g = NREQ-1.
- `req` is sampled only in IDLE. Deasserting `req` mid-transaction does not abort the frame; `ack` is still issued.
- `m_din` is held stable from START until DONE.
- Reset values: state IDLE, `ptr` 0. All outputs are 0: `gnt`, `ack`, `rx_dat`, `err`, `busy`, `m_st`, `m_din`.
- Reset mid-frame returns the FSM to IDLE at once with no `ack`. The attached master is reset by the same `rst`.

## Timing
- IDLE to `m_st` high: 2 cycles (grant register, then START).
- `m_st` high to `ack` pulse: frame time plus 2 cycles.
- After `ack` the FSM is in IDLE, so a new grant is possible on the following cycle. Minimum gap between two `m_st` pulses is frame time plus 4 cycles.
- Timeout counter: 0 in START, increments each cycle in WAIT_LO, and trips when it equals TIMEOUT.
- Simultaneous requests are served one per transaction in round-robin order, so no requester waits more than NREQ-1 transactions.
- `req` rising in the same cycle as `ack` for another requester is seen in the next IDLE cycle.

## Structure
- Package `spi_pkg`: FSM state enum (IDLE, START, WAIT_LO, WAIT_HI, DONE) and the timeout counter width function `$clog2(TIMEOUT+1)`.
- Sub-module `rr_pick`: combinational round-robin picker. Inputs are `req` and `ptr`; outputs are the one-hot winner and its index. The FSM, counters and registers stay in `spi_arbiter`.
- Testbench top wires `spi_arbiter` to a `spi_master`/`spi_slave` pair with WIDTH=13, CLKFREQ=8, SPIFREQ=2.

## Test plan
- Single request: `req`=0001, `tx_dat[0]`=0x1ABC, slave `din`=0x0F0F -> one `m_st` pulse, slave `dout`=0x1ABC, `ack`=0001 with `rx_dat`=0x0F0F, `err`=0.
- All four request at once with distinct words: grants are served in order 0,1,2,3. Each `ack` goes to the matching requester, and no `m_st` overlaps a frame.
- Fairness: requester 0 keeps `req` high continuously while requester 2 requests once -> order is 0, 2, 0 (`ptr` wraps correctly).
- Drop `req[1]` mid-frame -> the frame completes and `ack[1]` still pulses.
- `m_load` forced high (master disconnected), TIMEOUT=16 -> `ack` and `err` pulse 17 cycles after `m_st`, `rx_dat` unchanged.
- Assert `rst` during WAIT_HI -> next cycle all outputs are 0 and state is IDLE, no `ack` is issued, and the next request is served normally with `ptr`=0.
